// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ready handshake and loads IF/ID.
// Optional perf counters (fetch_cnt, flush_cnt) are enabled by defining IF_PERF_CNT_EN.
`timescale 1ns/1ps
module if_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] pc_out,
    input  logic [15:0] pred_next_pc,
    output logic        i_read,
    output logic [15:0] i_address,
    input  logic        i_ready,
    input  logic [15:0] i_data,
    input  logic        id_stall,
    input  logic        flush,
    input  logic [15:0] redirect_pc,
    output logic        ifid_valid,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc,
    output logic [15:0] ifid_pred_pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0] fetch_cnt,
    output logic [15:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {StFetch, StHold, StDrain} state_e;

    state_e      r_state, w_state_d;
    logic [15:0] r_pc, w_pc_d;
    logic [15:0] r_req_addr, w_req_addr_d;
    logic        r_ifid_valid, w_ifid_valid_d;
    logic [15:0] r_ifid_instr, w_ifid_instr_d;
    logic [15:0] r_ifid_pc, w_ifid_pc_d;
    logic [15:0] r_ifid_pred_pc, w_ifid_pred_pc_d;
    logic [15:0] r_hold_instr, w_hold_instr_d;
    logic [15:0] r_hold_pred_pc, w_hold_pred_pc_d;

    logic w_id_accept;
    logic w_id_consume;
    logic w_ifid_load;

    assign w_id_accept  = !r_ifid_valid || !id_stall;
    assign w_id_consume = r_ifid_valid && !id_stall;

    always_comb begin
        w_state_d        = r_state;
        w_pc_d           = r_pc;
        w_ifid_valid_d   = r_ifid_valid;
        w_ifid_instr_d   = r_ifid_instr;
        w_ifid_pc_d      = r_ifid_pc;
        w_ifid_pred_pc_d = r_ifid_pred_pc;
        w_hold_instr_d   = r_hold_instr;
        w_hold_pred_pc_d = r_hold_pred_pc;
        w_ifid_load      = 1'b0;

        if (flush) begin
            w_ifid_valid_d   = 1'b0;
            w_ifid_instr_d   = NOP_INSTR;
            w_pc_d           = redirect_pc;
            w_hold_instr_d   = NOP_INSTR;
            w_hold_pred_pc_d = '0;
            // An outstanding request must complete before the redirected fetch issues.
            case (r_state)
                StFetch: w_state_d = i_ready ? StFetch : StDrain;
                StDrain: w_state_d = i_ready ? StFetch : StDrain;
                default: w_state_d = StFetch;
            endcase
        end else begin
            case (r_state)
                StFetch: begin
                    if (i_ready) begin
                        if (w_id_accept) begin
                            w_ifid_load      = 1'b1;
                            w_ifid_valid_d   = 1'b1;
                            w_ifid_instr_d   = i_data;
                            w_ifid_pc_d      = r_pc;
                            w_ifid_pred_pc_d = pred_next_pc;
                            w_pc_d           = pred_next_pc;
                        end else begin
                            w_hold_instr_d   = i_data;
                            w_hold_pred_pc_d = pred_next_pc;
                            w_state_d        = StHold;
                        end
                    end else if (w_id_consume) begin
                        w_ifid_valid_d = 1'b0;
                        w_ifid_instr_d = NOP_INSTR;
                    end
                end
                StHold: begin
                    if (w_id_accept) begin
                        w_ifid_load      = 1'b1;
                        w_ifid_valid_d   = 1'b1;
                        w_ifid_instr_d   = r_hold_instr;
                        w_ifid_pc_d      = r_pc;
                        w_ifid_pred_pc_d = r_hold_pred_pc;
                        w_pc_d           = r_hold_pred_pc;
                        w_state_d        = StFetch;
                    end
                end
                StDrain: begin
                    if (i_ready) begin
                        w_state_d = StFetch;
                    end
                end
                default: w_state_d = StFetch;
            endcase
        end

        // Request address follows the PC only once a fresh fetch can issue.
        w_req_addr_d = (w_state_d == StFetch) ? w_pc_d : r_req_addr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= StFetch;
            r_pc           <= RESET_PC;
            r_req_addr     <= RESET_PC;
            r_ifid_valid   <= 1'b0;
            r_ifid_instr   <= NOP_INSTR;
            r_ifid_pc      <= '0;
            r_ifid_pred_pc <= '0;
            r_hold_instr   <= NOP_INSTR;
            r_hold_pred_pc <= '0;
        end else begin
            r_state        <= w_state_d;
            r_pc           <= w_pc_d;
            r_req_addr     <= w_req_addr_d;
            r_ifid_valid   <= w_ifid_valid_d;
            r_ifid_instr   <= w_ifid_instr_d;
            r_ifid_pc      <= w_ifid_pc_d;
            r_ifid_pred_pc <= w_ifid_pred_pc_d;
            r_hold_instr   <= w_hold_instr_d;
            r_hold_pred_pc <= w_hold_pred_pc_d;
        end
    end

    // Request is dropped immediately while reset is held.
    assign i_read       = reset_n && (r_state != StHold);
    assign i_address    = r_req_addr;
    assign pc_out       = r_pc;
    assign ifid_valid   = r_ifid_valid;
    assign ifid_instr   = r_ifid_instr;
    assign ifid_pc      = r_ifid_pc;
    assign ifid_pred_pc = r_ifid_pred_pc;

`ifdef IF_PERF_CNT_EN
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_ifid_load) begin
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end
            if (flush) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed segments push expected IF/ID loads,
// a negedge monitor pops and compares each new IF/ID entry.
`timescale 1ns/1ps
module tb_if_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic [15:0] pc_out;
    logic [15:0] pred_next_pc;
    logic        i_read;
    logic [15:0] i_address;
    logic        i_ready;
    logic [15:0] i_data;
    logic        id_stall;
    logic        flush;
    logic [15:0] redirect_pc;
    logic        ifid_valid;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_pred_pc;
`ifdef IF_PERF_CNT_EN
    logic [15:0] fetch_cnt;
    logic [15:0] flush_cnt;
`endif

    if_fetch_unit #(
        .RESET_PC  (16'h0000),
        .NOP_INSTR (16'h0000)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pc_out       (pc_out),
        .pred_next_pc (pred_next_pc),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_ready      (i_ready),
        .i_data       (i_data),
        .id_stall     (id_stall),
        .flush        (flush),
        .redirect_pc  (redirect_pc),
        .ifid_valid   (ifid_valid),
        .ifid_instr   (ifid_instr),
        .ifid_pc      (ifid_pc),
        .ifid_pred_pc (ifid_pred_pc)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt    (fetch_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pred;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] mem [0:255];
    int          lat;
    int          wait_cnt;
    logic        taken_en;
    logic [15:0] taken_src;
    logic [15:0] taken_tgt;
    logic        saw_abcd;
    logic        prev_valid;
    logic        prev_stall;

    // Predictor model: PC+1 unless a taken branch is programmed for this PC.
    assign pred_next_pc = (taken_en && pc_out == taken_src) ? taken_tgt : pc_out + 16'd1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] instr, input logic [15:0] pc, input logic [15:0] pred);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.pred  = pred;
        exp_q.push_back(e);
    endtask

    // Memory: raises a one-cycle i_ready after lat request cycles, clears it after the edge.
    initial begin
        i_ready  = 1'b0;
        i_data   = 16'h0000;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (!i_read) begin
                wait_cnt = 0;
            end else if (!i_ready) begin
                if (wait_cnt >= lat) begin
                    i_ready = 1'b1;
                    i_data  = mem[i_address[7:0]];
                end else begin
                    wait_cnt++;
                end
            end
            @(posedge clk);
            #1;
            if (i_ready) begin
                i_ready  = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Monitor: a fresh IF/ID entry appears when valid and the previous one was consumed or empty.
    initial begin
        exp_t e;
        prev_valid = 1'b0;
        prev_stall = 1'b0;
        saw_abcd   = 1'b0;
        forever begin
            @(negedge clk);
            if (ifid_valid && (!prev_valid || !prev_stall)) begin
                n_checks++;
                if (ifid_instr == 16'hABCD) saw_abcd = 1'b1;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL ifid_unexpected: got instr=%h pc=%h pred=%h, required none",
                             ifid_instr, ifid_pc, ifid_pred_pc);
                end else begin
                    e = exp_q.pop_front();
                    if ({ifid_instr, ifid_pc, ifid_pred_pc} !== e) begin
                        n_errors++;
                        $display("FAIL ifid_entry: got instr=%h pc=%h pred=%h, required instr=%h pc=%h pred=%h",
                                 ifid_instr, ifid_pc, ifid_pred_pc, e.instr, e.pc, e.pred);
                    end
                end
            end
            prev_valid = ifid_valid;
            prev_stall = id_stall;
        end
    end

    task automatic wait_addr(input logic [15:0] a);
        int n;
        n = 0;
        while (!(i_read && i_address == a) && n < 40) begin
            tick();
            n++;
        end
        chk("wait_addr_reached", {15'd0, (i_read && i_address == a)}, 16'd1);
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk("queue_drained", 16'(exp_q.size()), 16'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_i_read"},       {15'd0, i_read},     16'd0);
        chk({tag, "_pc_out"},       pc_out,              16'h0000);
        chk({tag, "_i_address"},    i_address,           16'h0000);
        chk({tag, "_ifid_valid"},   {15'd0, ifid_valid}, 16'd0);
        chk({tag, "_ifid_instr"},   ifid_instr,          16'h0000);
        chk({tag, "_ifid_pc"},      ifid_pc,             16'h0000);
        chk({tag, "_ifid_pred_pc"}, ifid_pred_pc,        16'h0000);
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        flush       = 1'b0;
        id_stall    = 1'b0;
        redirect_pc = 16'h0000;
        taken_en    = 1'b0;
        lat         = 1;
        exp_q.delete();
        repeat (2) tick();
        chk_reset_vals("rst");
        reset_n = 1'b1;
        #1;
        chk("post_rst_i_read",    {15'd0, i_read}, 16'd1);
        chk("post_rst_i_address", i_address,       16'h0000);
    endtask

    initial begin
        reset_n     = 1'b0;
        flush       = 1'b0;
        id_stall    = 1'b0;
        redirect_pc = 16'h0000;
        taken_en    = 1'b0;
        taken_src   = 16'h0000;
        taken_tgt   = 16'h0000;
        lat         = 1;
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        mem[5] = 16'h6123;

        // Streaming fetch, then a stall while pc=5 returns 6123.
        do_reset();
        push(16'h1000, 16'h0000, 16'h0001);
        push(16'h1001, 16'h0001, 16'h0002);
        push(16'h1002, 16'h0002, 16'h0003);
        push(16'h1003, 16'h0003, 16'h0004);
        push(16'h1004, 16'h0004, 16'h0005);
        push(16'h6123, 16'h0005, 16'h0006);
        wait_addr(16'h0005);
        id_stall = 1'b1;
        tick();
        tick();
        chk("hold_i_read",     {15'd0, i_read},     16'd0);
        chk("hold_ifid_valid", {15'd0, ifid_valid}, 16'd1);
        chk("hold_ifid_instr", ifid_instr,          16'h1004);
        chk("hold_ifid_pc",    ifid_pc,             16'h0004);
        chk("hold_pc_out",     pc_out,              16'h0005);
        tick();
        chk("hold2_i_read",    {15'd0, i_read},     16'd0);
        id_stall = 1'b0;
        tick();
        chk("rel_ifid_instr",   ifid_instr,   16'h6123);
        chk("rel_ifid_pc",      ifid_pc,      16'h0005);
        chk("rel_ifid_pred_pc", ifid_pred_pc, 16'h0006);
        chk("rel_pc_out",       pc_out,       16'h0006);
        chk("rel_i_address",    i_address,    16'h0006);
        wait_empty();

        // Flush while the request to 0x0007 is outstanding.
        do_reset();
        taken_en  = 1'b1;
        taken_src = 16'h0000;
        taken_tgt = 16'h0007;
        push(16'h1000, 16'h0000, 16'h0007);
        push(16'h1040, 16'h0040, 16'h0041);
        wait_addr(16'h0007);
        lat         = 2;
        flush       = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        flush = 1'b0;
        chk("drain_i_read",     {15'd0, i_read},     16'd1);
        chk("drain_i_address",  i_address,           16'h0007);
        chk("drain_ifid_valid", {15'd0, ifid_valid}, 16'd0);
        chk("drain_pc_out",     pc_out,              16'h0040);
`ifdef IF_PERF_CNT_EN
        chk("cnt_fetch_after_flush", fetch_cnt, 16'd1);
        chk("cnt_flush_after_flush", flush_cnt, 16'd1);
`endif
        tick();
        chk("drain2_i_address", i_address, 16'h0007);
        tick();
        chk("redir_i_address",  i_address,           16'h0040);
        chk("redir_ifid_valid", {15'd0, ifid_valid}, 16'd0);
        wait_empty();

        // Flush coincident with i_ready carrying ABCD, with ID also stalled.
        do_reset();
        mem[1]   = 16'hABCD;
        saw_abcd = 1'b0;
        push(16'h1000, 16'h0000, 16'h0001);
        push(16'h1050, 16'h0050, 16'h0051);
        wait_addr(16'h0001);
        id_stall = 1'b1;
        tick();
        flush       = 1'b1;
        redirect_pc = 16'h0050;
        tick();
        flush    = 1'b0;
        id_stall = 1'b0;
        chk("coin_ifid_valid", {15'd0, ifid_valid}, 16'd0);
        chk("coin_ifid_instr", ifid_instr,          16'h0000);
        chk("coin_i_address",  i_address,           16'h0050);
        chk("coin_i_read",     {15'd0, i_read},     16'd1);
        wait_empty();
        chk("abcd_discarded", {15'd0, saw_abcd}, 16'd0);
        mem[1] = 16'h1001;

        // Taken branch from 0x0003 to 0x0020.
        do_reset();
        taken_en  = 1'b1;
        taken_src = 16'h0003;
        taken_tgt = 16'h0020;
        push(16'h1000, 16'h0000, 16'h0001);
        push(16'h1001, 16'h0001, 16'h0002);
        push(16'h1002, 16'h0002, 16'h0003);
        push(16'h1003, 16'h0003, 16'h0020);
        push(16'h1020, 16'h0020, 16'h0021);
        wait_addr(16'h0020);
        chk("taken_pc_out",       pc_out,       16'h0020);
        chk("taken_ifid_pred_pc", ifid_pred_pc, 16'h0020);
        chk("taken_ifid_pc",      ifid_pc,      16'h0003);
        wait_empty();

        // Asynchronous reset while in HOLD.
        do_reset();
        push(16'h1000, 16'h0000, 16'h0001);
        wait_addr(16'h0001);
        id_stall = 1'b1;
        tick();
        tick();
        chk("pre_rst_hold_i_read", {15'd0, i_read}, 16'd0);
        chk("pre_rst_ifid_instr",  ifid_instr,      16'h1000);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
`ifdef IF_PERF_CNT_EN
        chk("async_rst_fetch_cnt", fetch_cnt, 16'd0);
        chk("async_rst_flush_cnt", flush_cnt, 16'd0);
`endif
        id_stall = 1'b0;
        exp_q.delete();
        tick();
        reset_n = 1'b1;
        #1;
        chk("rel_first_i_address", i_address,       16'h0000);
        chk("rel_first_i_read",    {15'd0, i_read}, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage: owns the architectural PC and drives the predictor's PC input.
- Takes the predictor's next_PC as the next fetch address.
- Runs a req/ready handshake with instruction memory and loads the IF/ID pipeline register, which carries the predicted next PC forward for later mispredict comparison.
- On flush, redirects to the resolved correct PC and squashes any in-flight or buffered fetch.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0000, instruction word placed in ifid_instr whenever ifid_valid is 0.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  asynchronous active-low reset.
- pc_out  out  16  current fetch PC; connects to predictor PC.
- pred_next_pc  in  16  predictor next_PC for pc_out (combinational).
- i_read  out  1  instruction-memory read request.
- i_address  out  16  request address; held stable while i_read=1 and i_ready=0.
- i_ready  in  1  memory data valid for the current request, one-cycle pulse.
- i_data  in  16  fetched instruction; valid when i_ready=1.
- id_stall  in  1  ID cannot accept a new instruction this cycle.
- flush  in  1  mispredict/redirect from branch resolve (branch_signal).
- redirect_pc  in  16  correct PC; valid with flush.
- ifid_valid  out  1  IF/ID register holds a live instruction.
- ifid_instr  out  16  IF/ID instruction.
- ifid_pc  out  16  PC of ifid_instr.
- ifid_pred_pc  out  16  predicted next PC captured with ifid_instr.

Behaviour:
- Reset (async, reset_n=0):
  - pc=RESET_PC, req_addr=RESET_PC, state=FETCH.
  - ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pred_pc=0.
  - i_read=0 while reset is asserted; hold buffer cleared.
  - Reset mid-request abandons the request; memory must tolerate a dropped i_read.
- Output decode:
  - i_address=req_addr.
  - i_read=1 in FETCH and DRAIN, 0 in HOLD.
  - pc_out=pc.
  - req_addr tracks pc on entry to FETCH, so i_address=pc in FETCH.
- ID consumption: an instruction is consumed at a clock edge when ifid_valid=1 and id_stall=0. "ID can accept" means ifid_valid=0 or id_stall=0.
- FETCH, i_ready=1, no flush:
  - If ID can accept: load IF/ID with valid=1, instr=i_data, pc=pc, pred_pc=pred_next_pc. Set pc<=pred_next_pc, stay in FETCH; the next request issues the following cycle.
  - Else: capture i_data and pred_next_pc into the hold buffer, go to HOLD. pc is unchanged.
- FETCH, i_ready=0: keep the request; if ID consumes, ifid_valid<=0 and ifid_instr<=NOP_INSTR.
- HOLD: when ID can accept, move buffer to IF/ID with valid=1, set pc<=buffered pred_pc, go to FETCH. Otherwise remain in HOLD.
- Flush (highest priority, any state):
  - Set ifid_valid<=0, ifid_instr<=NOP_INSTR, pc<=redirect_pc; clear the hold buffer.
  - In FETCH with i_ready=0, the request is outstanding: go to DRAIN, keeping req_addr at the old address.
  - In FETCH with i_ready=1: discard i_data, go to FETCH at redirect_pc.
  - In HOLD or DRAIN: go to FETCH at redirect_pc. In DRAIN with i_ready=0, stay in DRAIN with pc updated to the newest redirect_pc.
- DRAIN: hold i_read with the old address until i_ready, discard the data, then go to FETCH at pc. Nothing enters IF/ID while in DRAIN.
- Flush and id_stall together: flush wins and IF/ID is invalidated.
- Arithmetic: none inside the block; the predictor supplies PC+1 or the target. All 16-bit, no wrap handling needed beyond natural 16-bit behaviour.
- Throughput: with a 1-cycle memory and no stalls, one instruction every 2 cycles (request cycle plus ready cycle). Latency from the i_ready edge to ifid_valid is 1 clock.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined: adds outputs fetch_cnt (16) and flush_cnt (16).
  - fetch_cnt increments on each IF/ID load with valid=1.
  - flush_cnt increments on each cycle where flush=1.
  - Both wrap at 16'hFFFF->0 and reset to 0 asynchronously.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, memory ready 1 cycle after request, pred_next_pc=pc+1, no stall: i_address shows 0,1,2; ifid_pc/ifid_instr follow with ifid_valid=1 and ifid_pred_pc=ifid_pc+1.
- id_stall=1 for 3 cycles when i_ready returns 16'h6123 for pc=5: state HOLD, i_read=0, ifid unchanged. On release, ifid_instr=16'h6123, ifid_pc=5, pc=pred value.
- flush with redirect_pc=16'h0040 while a request to 0x0007 is outstanding (ready arrives 2 cycles later): i_address stays 0x0007 until ready, data discarded, ifid_valid=0, next i_address=0x0040.
- flush coincident with i_ready (data 16'hABCD): ifid_valid=0, ABCD never appears, next request at redirect_pc.
- Predictor returns taken target 0x0020 for pc=0x0003: after the fetch completes, pc_out=0x0020 and ifid_pred_pc=0x0020.
- Assert reset_n low mid-HOLD: outputs immediately at reset values. After release, the first i_address=RESET_PC. With IF_PERF_CNT_EN, both counters read 0.
